// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC rotation-mode sequencer: one micro-rotation per clock on a shared
// saturating X/Y datapath, with an accept-in / hold-out valid/ready handshake.
module cordic_iter_ctrl #(
    parameter int                 ITER   = 14,
    parameter logic signed [15:0] K_INIT = 16'sd9949
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] angle_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] cos_out,
    output logic signed [15:0] sin_out,
    output logic               range_err,
    output logic               busy
);

    localparam logic signed [15:0] ANGLE_MAX = 16'sd12868;
    localparam logic signed [15:0] ANGLE_MIN = -16'sd12868;
    localparam logic [3:0]         LAST_ITER = 4'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic signed [15:0] x_q, x_d;
    logic signed [15:0] y_q, y_d;
    logic signed [15:0] z_q, z_d;
    logic [3:0]         iter_q, iter_d;
    logic               rangeFlag_q, rangeFlag_d;
    logic signed [15:0] cos_q, cos_d;
    logic signed [15:0] sin_q, sin_d;
    logic               rangeErr_q, rangeErr_d;

    logic               rotDir;
    logic signed [15:0] xShift, yShift, atanVal, angleClamped, xNext, yNext;
    logic signed [16:0] xSum, ySum;
    logic               angleOutOfRange;

    function automatic logic signed [15:0] atanLut(input logic [3:0] idx);
        case (idx)
            4'd0:    atanLut = 16'sd6434;
            4'd1:    atanLut = 16'sd3798;
            4'd2:    atanLut = 16'sd2007;
            4'd3:    atanLut = 16'sd1019;
            4'd4:    atanLut = 16'sd511;
            4'd5:    atanLut = 16'sd256;
            4'd6:    atanLut = 16'sd128;
            4'd7:    atanLut = 16'sd64;
            4'd8:    atanLut = 16'sd32;
            4'd9:    atanLut = 16'sd16;
            4'd10:   atanLut = 16'sd8;
            4'd11:   atanLut = 16'sd4;
            4'd12:   atanLut = 16'sd2;
            4'd13:   atanLut = 16'sd1;
            4'd14:   atanLut = 16'sd1;
            default: atanLut = 16'sd0;
        endcase
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v > 17'sd32767)
            sat16 = 16'sh7FFF;
        else if (v < -17'sd32768)
            sat16 = 16'sh8000;
        else
            sat16 = v[15:0];
    endfunction

    // Shared micro-rotation datapath; sums are one bit wider so saturation sees the carry.
    always_comb begin
        rotDir  = z_q[15];
        xShift  = x_q >>> iter_q;
        yShift  = y_q >>> iter_q;
        atanVal = atanLut(iter_q);
        if (rotDir) begin
            xSum = $signed({x_q[15], x_q}) + $signed({yShift[15], yShift});
            ySum = $signed({y_q[15], y_q}) - $signed({xShift[15], xShift});
        end else begin
            xSum = $signed({x_q[15], x_q}) - $signed({yShift[15], yShift});
            ySum = $signed({y_q[15], y_q}) + $signed({xShift[15], xShift});
        end
        xNext = sat16(xSum);
        yNext = sat16(ySum);

        angleOutOfRange = (angle_in > ANGLE_MAX) || (angle_in < ANGLE_MIN);
        if (angle_in > ANGLE_MAX)
            angleClamped = ANGLE_MAX;
        else if (angle_in < ANGLE_MIN)
            angleClamped = ANGLE_MIN;
        else
            angleClamped = angle_in;
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        iter_d      = iter_q;
        rangeFlag_d = rangeFlag_q;
        cos_d       = cos_q;
        sin_d       = sin_q;
        rangeErr_d  = rangeErr_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d         = K_INIT;
                    y_d         = 16'sd0;
                    z_d         = angleClamped;
                    iter_d      = 4'd0;
                    rangeFlag_d = angleOutOfRange;
                    state_d     = ROTATE;
                end
            end
            ROTATE: begin
                x_d = xNext;
                y_d = yNext;
                z_d = rotDir ? (z_q + atanVal) : (z_q - atanVal);
                // Result registers are loaded only here so they hold across the next IDLE.
                if (iter_q == LAST_ITER) begin
                    iter_d     = 4'd0;
                    cos_d      = xNext;
                    sin_d      = yNext;
                    rangeErr_d = rangeFlag_q;
                    state_d    = DONE;
                end else begin
                    iter_d = iter_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            iter_q      <= '0;
            rangeFlag_q <= 1'b0;
            cos_q       <= '0;
            sin_q       <= '0;
            rangeErr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            iter_q      <= iter_d;
            rangeFlag_q <= rangeFlag_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            rangeErr_q  <= rangeErr_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ROTATE) || (state_q == DONE);
    assign cos_out   = cos_q;
    assign sin_out   = sin_q;
    assign range_err = rangeErr_q;

endmodule
